// File: rtl/seven_seg_scan_if.sv
// Bundle between the pattern generators and the seven-segment scanner.
// master drives seg_bus/load/blink_mask; slave drives seg_out/an_out/frame_done.
interface seven_seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [8*NUM_DIGITS-1:0] seg_bus;
    logic                    load;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [7:0]              seg_out;
    logic [NUM_DIGITS-1:0]   an_out;
    logic                    frame_done;

    modport master (
        output seg_bus, load, blink_mask,
        input  seg_out, an_out, frame_done
    );

    modport slave (
        input  seg_bus, load, blink_mask,
        output seg_out, an_out, frame_done
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment driver with blanking, blink, frame-aligned loads.
// Ports: clk, rst_n (async low), bus (slave): seg_bus/load/blink_mask in; seg_out/an_out/frame_done out.
module seven_seg_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000,
    parameter int BLINK_FRAMES = 60
) (
    input logic            clk,
    input logic            rst_n,
    seven_seg_scan_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [CW-1:0] cnt;
    logic [DW-1:0] dig;
    logic [FW-1:0] fcnt;
    logic          blink_on;

    logic [NUM_DIGITS-1:0][7:0] pending;
    logic [NUM_DIGITS-1:0][7:0] display;

    logic                  cnt_last;
    logic                  dig_last;
    logic                  wrap;
    logic                  blank;
    logic [NUM_DIGITS-1:0] an_next;
    logic [7:0]            seg_next;

    assign cnt_last = (cnt == CW'(REFRESH_DIV - 1));
    assign dig_last = (dig == DW'(NUM_DIGITS - 1));
    assign wrap     = cnt_last && dig_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            dig <= '0;
        end else begin
            cnt <= cnt_last ? '0 : cnt + 1'b1;
            if (cnt_last)
                dig <= dig_last ? '0 : dig + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt     <= '0;
            blink_on <= 1'b1;
        end else if (wrap) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt     <= '0;
                blink_on <= ~blink_on;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // A load on the wrap edge bypasses pending so it lands in the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= {NUM_DIGITS{8'hFF}};
            display <= {NUM_DIGITS{8'hFF}};
        end else begin
            if (bus.load)
                pending <= bus.seg_bus;
            if (wrap)
                display <= bus.load ? bus.seg_bus : pending;
        end
    end

    always_comb begin
        blank    = (cnt < CW'(BLANK_CYCLES)) ||
                   (!blink_on && bus.blink_mask[dig]);
        an_next  = '1;
        seg_next = 8'hFF;
        if (!blank) begin
            an_next[dig] = 1'b0;
            seg_next     = display[dig];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.seg_out    <= 8'hFF;
            bus.an_out     <= '1;
            bus.frame_done <= 1'b0;
        end else begin
            bus.seg_out    <= seg_next;
            bus.an_out     <= an_next;
            bus.frame_done <= wrap;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan (4 digits, 8-cycle slots, 2 blank, blink 2).
// Stimulus queues expected outputs per edge; a monitor pops and compares.
module tb_seven_seg_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   k = 0;
    int   cur = 0;

    typedef struct {
        int         k;
        logic [3:0] an;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t q[$];

    seven_seg_scan_if #(.NUM_DIGITS(4)) sif ();

    seven_seg_scan #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sif.slave)
    );

    always #5 clk = ~clk;

    // Expected output after edge k, from the documented timing rules.
    task automatic push_range(input int lo, input int hi,
                              input logic [31:0] data,
                              input logic [3:0] mask);
        exp_t e;
        for (int j = lo; j <= hi; j++) begin
            int c;
            int d;
            int f;
            logic bl;
            logic [3:0] one;
            c   = (j - 1) % 8;
            d   = ((j - 1) / 8) % 4;
            f   = (j - 1) / 32;
            one = 4'b0001;
            bl  = (c < 2) || (mask[d] && ((f / 2) % 2 == 1));
            e.k = j;
            e.an  = bl ? 4'hF : ~(one << d);
            e.seg = (bl || f == 0) ? 8'hFF : data[8*d +: 8];
            e.fd  = (j % 32 == 0);
            q.push_back(e);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (!rst_n) k = 0;
        else k++;
        while (q.size() > 0 && q[0].k <= k && rst_n) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (e.k != k) begin
                bad++;
                $display("FAIL missed_edge want=%0d at=%0d", e.k, k);
            end else if (sif.an_out !== e.an || sif.seg_out !== e.seg ||
                         sif.frame_done !== e.fd) begin
                bad++;
                $display("FAIL scan edge=%0d an=%b/%b seg=%h/%h fd=%b/%b",
                         k, sif.an_out, e.an, sif.seg_out, e.seg,
                         sif.frame_done, e.fd);
            end
        end
    end

    task automatic start_session(input logic [3:0] mask);
        rst_n = 1'b0;
        sif.load = 1'b0;
        sif.seg_bus = 32'hFFFF_FFFF;
        sif.blink_mask = mask;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cur = 0;
    endtask

    task automatic release_rst();
        rst_n = 1'b1;
    endtask

    task automatic goto_edge(input int n);
        repeat (n - cur) @(posedge clk);
        #2;
        cur = n;
    endtask

    task automatic load_at(input int e, input logic [31:0] data);
        goto_edge(e - 1);
        sif.load = 1'b1;
        sif.seg_bus = data;
        goto_edge(e);
        sif.load = 1'b0;
        sif.seg_bus = 32'hFFFF_FFFF;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        #2;
        total++;
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
            q.delete();
        end
    endtask

    initial begin
        sif.load = 1'b0;
        sif.seg_bus = 32'hFFFF_FFFF;
        sif.blink_mask = 4'b0000;

        // Reset scan order plus load alignment at edge 5.
        start_session(4'b0000);
        push_range(1, 48, 32'hFFFF_9F03, 4'b0000);
        release_rst();
        load_at(5, 32'hFFFF_9F03);
        drain();

        // Async reset mid-frame clears banks and outputs without a clock.
        start_session(4'b0000);
        push_range(1, 12, 32'hFFFF_FFFF, 4'b0000);
        release_rst();
        load_at(5, 32'hFFFF_FF03);
        goto_edge(12);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (sif.an_out !== 4'hF || sif.seg_out !== 8'hFF ||
            sif.frame_done !== 1'b0) begin
            bad++;
            $display("FAIL async_rst an=%b/1111 seg=%h/ff fd=%b/0",
                     sif.an_out, sif.seg_out, sif.frame_done);
        end
        drain();
        repeat (2) @(posedge clk);
        @(negedge clk);
        cur = 0;
        push_range(1, 40, 32'hFFFF_FFFF, 4'b0000);
        release_rst();
        drain();

        // Load exactly on the frame-wrap edge.
        start_session(4'b0000);
        push_range(1, 40, 32'hFFFF_FF25, 4'b0000);
        release_rst();
        load_at(32, 32'hFFFF_FF25);
        drain();

        // Last load within a frame wins.
        start_session(4'b0000);
        push_range(1, 40, 32'hFFFF_FF9F, 4'b0000);
        release_rst();
        load_at(10, 32'hFFFF_FF03);
        load_at(20, 32'hFFFF_FF9F);
        drain();

        // Blink digit 0 across frames 0..4.
        start_session(4'b0001);
        push_range(1, 160, 32'h9925_9F03, 4'b0001);
        sif.load = 1'b1;
        sif.seg_bus = 32'h9925_9F03;
        release_rst();
        goto_edge(1);
        sif.load = 1'b0;
        sif.seg_bus = 32'hFFFF_FFFF;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
